// File: rtl/usb_rx_link_ctrl_if.sv
// usb_rx_link_ctrl_if: PID/CRC16 receive inputs and handshake/status outputs of the link controller
interface usb_rx_link_ctrl_if;
  logic       rx_pid_valid;
  logic [3:0] rx_pid;
  logic       rx_token_ok;
  logic       rx_sop_en;
  logic       rx_lt_eop_en;
  logic       rx_crc16_err;
  logic       ep_stall;
  logic       ep_nak;
  logic       tx_hs_ready;
  logic       rx_data_on;
  logic       tx_hs_req;
  logic [3:0] tx_hs_pid;
  logic       data_toggle;
  logic       rx_pkt_accept;
  logic       rx_timeout;
  modport slave (
    input  rx_pid_valid, rx_pid, rx_token_ok, rx_sop_en, rx_lt_eop_en, rx_crc16_err,
           ep_stall, ep_nak, tx_hs_ready,
    output rx_data_on, tx_hs_req, tx_hs_pid, data_toggle, rx_pkt_accept, rx_timeout
  );
  modport master (
    output rx_pid_valid, rx_pid, rx_token_ok, rx_sop_en, rx_lt_eop_en, rx_crc16_err,
           ep_stall, ep_nak, tx_hs_ready,
    input  rx_data_on, tx_hs_req, tx_hs_pid, data_toggle, rx_pkt_accept, rx_timeout
  );
endinterface

// File: rtl/usb_rx_link_ctrl.sv
// usb_rx_link_ctrl: sequences the USB DATA phase, tracks DATA0/1 toggle and requests the handshake PID
module usb_rx_link_ctrl #(
  parameter int TIMEOUT_CYC = 18
) (
  input logic clk,
  input logic rst_n,
  usb_rx_link_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_DATA, DATA, HS_REQ} state_e;
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] HS_ACK    = 4'b0010;
  localparam logic [3:0] HS_NAK    = 4'b1010;
  localparam logic [3:0] HS_STALL  = 4'b1110;
  localparam logic [7:0] TMO_LOAD  = 8'(TIMEOUT_CYC - 1);
  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       pid_bit_q, pid_bit_d;
  logic       toggle_q, toggle_d;
  logic [3:0] hs_pid_q, hs_pid_d;
  logic       accept_q, accept_d;
  logic       timeout_q, timeout_d;
  logic       hs_req_q, data_on_q;
  logic       tok_setup, tok;
  assign tok_setup = bus.rx_pid_valid & bus.rx_token_ok & (bus.rx_pid == PID_SETUP);
  assign tok       = tok_setup | (bus.rx_pid_valid & bus.rx_token_ok & (bus.rx_pid == PID_OUT));
  // next-state: token decode, SOP wait with timeout, EOP handshake selection, handshake hold
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pid_bit_d = pid_bit_q;
    toggle_d  = toggle_q;
    hs_pid_d  = hs_pid_q;
    accept_d  = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tok) begin
          state_d  = WAIT_DATA;
          timer_d  = TMO_LOAD;
          toggle_d = tok_setup ? 1'b0 : toggle_q;
        end
      end
      WAIT_DATA: begin
        timer_d = (timer_q != 8'd0) ? timer_q - 8'd1 : 8'd0;
        if (tok) begin
          timer_d  = TMO_LOAD;
          toggle_d = tok_setup ? 1'b0 : toggle_q;
        end else if (bus.rx_sop_en) begin
          state_d = DATA;
        end else if (timer_q == 8'd0) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      DATA: begin
        if (bus.rx_pid_valid && bus.rx_pid[2:0] == 3'b011) pid_bit_d = bus.rx_pid[3];
        if (bus.rx_lt_eop_en) begin
          state_d  = bus.rx_crc16_err ? IDLE : HS_REQ;
          hs_pid_d = bus.rx_crc16_err ? hs_pid_q :
                     bus.ep_stall ? HS_STALL :
                     (pid_bit_q != toggle_q) ? HS_ACK :
                     bus.ep_nak ? HS_NAK : HS_ACK;
          accept_d = !bus.rx_crc16_err && !bus.ep_stall && (pid_bit_q == toggle_q) && !bus.ep_nak;
          toggle_d = toggle_q ^ accept_d;
        end
      end
      HS_REQ: state_d = (hs_req_q && bus.tx_hs_ready) ? IDLE : HS_REQ;
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= 8'd0;
      pid_bit_q <= 1'b0;
      toggle_q  <= 1'b0;
      hs_pid_q  <= 4'b0000;
      accept_q  <= 1'b0;
      timeout_q <= 1'b0;
      hs_req_q  <= 1'b0;
      data_on_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pid_bit_q <= pid_bit_d;
      toggle_q  <= toggle_d;
      hs_pid_q  <= hs_pid_d;
      accept_q  <= accept_d;
      timeout_q <= timeout_d;
      hs_req_q  <= (state_d == HS_REQ);
      data_on_q <= (state_d == WAIT_DATA) || (state_d == DATA);
    end
  end
  assign bus.rx_data_on    = data_on_q;
  assign bus.tx_hs_req     = hs_req_q;
  assign bus.tx_hs_pid     = hs_pid_q;
  assign bus.data_toggle   = toggle_q;
  assign bus.rx_pkt_accept = accept_q;
  assign bus.rx_timeout    = timeout_q;
endmodule

// File: doc/usb_rx_link_ctrl.md
Name: usb_rx_link_ctrl

Overview:
- Receive-side link controller that sequences the USB DATA phase.
- Decodes incoming token PIDs, enables the CRC16 receive stage (rx_data_on) only while a DATA packet is expected or in flight, and tracks the DATA0/DATA1 toggle.
- Requests the handshake PID (ACK/NAK/STALL) from the transmit side.
- Sits between the PID/CRC5 receive path, the CRC16 receive stage and the transmit handshake generator.

Parameters:
- TIMEOUT_CYC, 18, clock cycles to wait for DATA SOP after an accepted OUT/SETUP token before abandoning the transaction (1..255).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_pid_valid  input  1  one-cycle pulse, rx_pid holds a checked PID
- rx_pid  input  4  PID[3:0]: OUT=0001, SETUP=1101, DATA0=0011, DATA1=1011
- rx_token_ok  input  1  address/endpoint match and CRC5 good for the token; qualified by rx_pid_valid
- rx_sop_en  input  1  pulse from CRC16 stage: DATA SOP accepted
- rx_lt_eop_en  input  1  pulse from CRC16 stage: DATA EOP delivered to the transfer layer
- rx_crc16_err  input  1  CRC16 check failed; sampled only with rx_lt_eop_en
- ep_stall  input  1  endpoint halted (level)
- ep_nak  input  1  endpoint buffer unable to accept (level)
- tx_hs_ready  input  1  transmit side accepts the handshake request
- rx_data_on  output  1  enables the CRC16 receive stage
- tx_hs_req  output  1  handshake request, held until accepted
- tx_hs_pid  output  4  ACK=0010, NAK=1010, STALL=1110; held stable while tx_hs_req=1
- data_toggle  output  1  expected DATA PID: 0=DATA0, 1=DATA1
- rx_pkt_accept  output  1  one-cycle pulse: packet good, in sequence, ACKed
- rx_timeout  output  1  one-cycle pulse: WAIT_DATA expired

Behaviour:
- Reset values: all outputs 0, state IDLE, timer 0, latched data-PID bit 0, tx_hs_pid 0000. Reset mid-transaction returns to IDLE immediately and drops tx_hs_req even if the handshake has not been accepted.
- All outputs are registered. rx_data_on=1 exactly in WAIT_DATA and DATA, so it rises one cycle after the token pulse.
- IDLE:
  - rx_pid_valid & rx_token_ok & PID=OUT -> WAIT_DATA; timer loads TIMEOUT_CYC-1.
  - Same for PID=SETUP, and data_toggle is also forced to 0.
  - Any other PID, or rx_token_ok=0 -> stay in IDLE.
- WAIT_DATA:
  - Timer decrements every cycle.
  - rx_sop_en -> DATA.
  - Timer==0 and no rx_sop_en -> IDLE with rx_timeout pulsed; toggle unchanged.
  - If rx_sop_en and expiry coincide, rx_sop_en wins.
  - A new valid matching OUT/SETUP token restarts the transaction exactly as from IDLE (timer reloads).
- DATA:
  - An rx_pid_valid with PID DATA0/DATA1 latches pid bit 3. Any other PID is ignored.
  - rx_lt_eop_en evaluates the following, in priority order:
    1. rx_crc16_err=1 -> IDLE, no handshake, toggle unchanged.
    2. ep_stall=1 -> HS_REQ with STALL.
    3. latched bit != data_toggle -> HS_REQ with ACK; no toggle flip; no rx_pkt_accept (duplicate packet).
    4. ep_nak=1 -> HS_REQ with NAK; no flip.
    5. Otherwise -> HS_REQ with ACK; data_toggle flips; rx_pkt_accept pulses.
  - The toggle flip and rx_pkt_accept take effect in the cycle after rx_lt_eop_en, together with tx_hs_req rising.
  - DATA has no timeout; the PHY EOP bounds it.
- HS_REQ:
  - tx_hs_req=1 and tx_hs_pid held.
  - tx_hs_req & tx_hs_ready -> IDLE; tx_hs_req falls the next cycle.
  - Tokens arriving in HS_REQ are ignored.
  - ready may be asserted in the first request cycle, giving a 1-cycle request.
- Timer is 8 bits wide with no wrap: it only decrements in WAIT_DATA and never goes below 0.

Test Plan:
- OUT token (ok=1), rx_sop_en at +3, DATA0 PID, rx_lt_eop_en at +10, err=0, tx_hs_ready tied 1 -> rx_data_on high from cycle after token until the HS_REQ entry; tx_hs_req 1 cycle, tx_hs_pid=0010; data_toggle 0->1; rx_pkt_accept pulses once.
- Repeat the same DATA0 packet with toggle=1 -> ACK 0010 sent, data_toggle stays 1, no rx_pkt_accept.
- OUT token, no SOP, TIMEOUT_CYC=18 -> rx_timeout pulses exactly 18 cycles after WAIT_DATA entry; rx_data_on falls with it; no handshake. Then repeat with rx_sop_en in the expiry cycle -> DATA entered, no rx_timeout.
- Good DATA1 with ep_stall=1 and ep_nak=1 -> STALL 1110, toggle unchanged. Same packet with ep_stall=0 -> NAK 1010. Same packet with rx_crc16_err=1 -> no tx_hs_req, back to IDLE.
- SETUP token while toggle=1 -> data_toggle=0 next cycle. Then hold tx_hs_ready=0 for 5 cycles in HS_REQ and assert rst_n=0 on cycle 3 -> tx_hs_req and all outputs go 0 immediately; state IDLE.
